// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// Module : seg_pkg
// Brief  : Seven-segment code table and segment bit indices (logical, 1 = lit).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry n is the {g..a} pattern for hex digit n; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

`default_nettype wire

// File: rtl/seg_hex_decode.sv
// ----------------------------------------------------------------------------
// Module : seg_hex_decode
// Brief  : Combinational hex nibble to logical seven-segment pattern.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

`default_nettype wire

// File: rtl/seven_segment_scan.sv
// ----------------------------------------------------------------------------
// Module : seven_segment_scan
// Brief  : Time-multiplexed N-digit hex display driver with shadow registers,
//          leading-zero blanking and selectable output polarity.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an
);

  localparam int c_CNT_W = $clog2(REFRESH_DIV);
  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [c_CNT_W-1:0]       r_cnt;
  logic [c_IDX_W-1:0]       r_idx;
  logic [DIGITS-1:0][3:0]   r_value;
  logic [DIGITS-1:0]        r_dp;
  logic [6:0]               r_seg;
  logic                     r_dp_out;
  logic [DIGITS-1:0]        r_an;

  logic [DIGITS:0]          w_zero_from;
  logic                     w_blank;
  logic [3:0]               w_nib;
  logic [6:0]               w_seg_raw;
  logic [6:0]               w_seg_log;
  logic                     w_dp_log;
  logic [DIGITS-1:0]        w_an_hot;

  // w_zero_from[k] is set when every shadow nibble from k upward is zero.
  assign w_zero_from[DIGITS] = 1'b1;
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
      assign w_zero_from[k] = (r_value[k] == 4'h0) && w_zero_from[k+1];
    end
  endgenerate

  assign w_nib     = r_value[r_idx];
  assign w_blank   = blank_lz && (r_idx != '0) && w_zero_from[r_idx];
  assign w_seg_log = w_blank ? SEG_OFF : w_seg_raw;
  assign w_dp_log  = r_dp[r_idx] && !w_blank;
  assign w_an_hot  = DIGITS'(1) << r_idx;

  seg_hex_decode u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_dp    <= '0;
    end else if (load) begin
      r_value <= value;
      r_dp    <= dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (enable) begin
      if (r_cnt == c_CNT_W'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Outputs reflect the pre-edge index and shadow, one cycle behind them.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_an     <= {DIGITS{AN_ACTIVE_LOW}};
      r_seg    <= {7{SEG_ACTIVE_LOW}};
      r_dp_out <= SEG_ACTIVE_LOW;
    end else begin
      r_an     <= w_an_hot ^ {DIGITS{AN_ACTIVE_LOW}};
      r_seg    <= w_seg_log ^ {7{SEG_ACTIVE_LOW}};
      r_dp_out <= w_dp_log ^ SEG_ACTIVE_LOW;
    end
  end

  assign seg    = r_seg;
  assign dp_out = r_dp_out;
  assign an     = r_an;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
// ----------------------------------------------------------------------------
// Module : tb_seven_segment_scan
// Brief  : Directed self-checking bench, DIGITS=4, REFRESH_DIV=4, active-low.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;

  int n_vec = 0;
  int n_err = 0;
  int lit = 0;
  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];

  seven_segment_scan #(
    .DIGITS         (4),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (load),
    .value    (value),
    .dp       (dp),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp_out   (dp_out),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] dpl);
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    for (int i = 0; i < 4; i++) exp_dp[i] = ~dpl[i];
  endtask

  // Each enabled edge shows the digit selected after lit-1 enabled edges.
  task automatic run(input int n, input string tag);
    int d;
    logic [3:0] hot;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      lit++;
      #1;
      d   = ((lit - 1) / 4) % 4;
      hot = 4'b0001 << d;
      chk_val({tag, "_an"},  {28'd0, an},     {28'd0, ~hot});
      chk_val({tag, "_seg"}, {25'd0, seg},    {25'd0, exp_seg[d]});
      chk_val({tag, "_dp"},  {31'd0, dp_out}, {31'd0, exp_dp[d]});
    end
  endtask

  task automatic chk_off(input string tag);
    chk_val({tag, "_an"},  {28'd0, an},     32'h0000_000F);
    chk_val({tag, "_seg"}, {25'd0, seg},    32'h0000_007F);
    chk_val({tag, "_dp"},  {31'd0, dp_out}, 32'h0000_0001);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_off("reset");

    rst = 1'b0;
    enable = 1'b1;
    set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
    lit = 0;
    run(16, "scan0");

    // Load 9A3F: the load edge still shows the old shadow.
    load = 1'b1; value = 16'h9A3F; dp = 4'b0100;
    run(1, "ld1_edge");
    load = 1'b0;
    set_exp(7'h0E, 7'h30, 7'h08, 7'h10, 4'b0100);
    run(16, "hex");

    // Leading-zero blanking on 0050.
    blank_lz = 1'b1;
    load = 1'b1; value = 16'h0050; dp = 4'b0000;
    run(1, "ld2_edge");
    load = 1'b0;
    set_exp(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b0000);
    run(24, "blank");

    // Now on the second cycle of digit 2's dwell; freeze the scan.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_off("disabled");
    end
    enable = 1'b1;
    run(7, "resume");

    // Load on the edge where the index advances 0 -> 1.
    run(2, "pre_adv");
    load = 1'b1; value = 16'h00B0; dp = 4'b0010;
    run(1, "adv_edge");
    load = 1'b0;
    set_exp(7'h40, 7'h03, 7'h7F, 7'h7F, 4'b0010);
    run(8, "adv_new");

    // Reset while digit 3 is lit with a load pending.
    run(2, "pre_rst");
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp = 4'b1111;
    @(posedge clk);
    #1;
    chk_off("midrst");
    rst = 1'b0; load = 1'b0;
    set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    lit = 0;
    run(8, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Parametrised, time-multiplexed N-digit seven-segment display driver.
- Successor to the single-digit combinational decoder: adds full hex decode (0-F), a latched display value, a refresh scan counter, per-digit decimal points, leading-zero blanking and selectable output polarity.
- Sits between core logic and the board display pins: one common segment bus plus one digit-enable (anode) line per digit.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2).
- SEG_ACTIVE_LOW, 1, 1 = seg/dp_out driven low to light a segment.
- AN_ACTIVE_LOW, 1, 1 = an driven low to enable a digit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = scan and display; 0 = all digits off, scan frozen
- load  in  1  1 = capture value/dp into shadow registers this edge
- value  in  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k, digit 0 = least significant
- dp  in  DIGITS  decimal point request per digit
- blank_lz  in  1  1 = blank leading zero digits
- seg  out  7  segments, seg[0]=a ... seg[6]=g
- dp_out  out  1  decimal point segment
- an  out  DIGITS  digit enables, an[k] = digit k

Behaviour:
- Reset (rst=1 at a clk edge): refresh counter=0, digit index=0, shadow value=0, shadow dp=0; every an, seg and dp_out bit at its inactive level (all-ones when the matching *_ACTIVE_LOW=1).
- Shadow: the edge with load=1 captures value and dp. load=0 holds the shadow registers. load is honoured even when enable=0.
- Refresh counter:
  - With enable=1 it counts 0..REFRESH_DIV-1.
  - At the edge where it equals REFRESH_DIV-1 it returns to 0 and the digit index advances.
  - The index wraps DIGITS-1 -> 0.
  - With enable=0 the counter and index hold their values.
- Outputs are registered from the current index and shadow, so an/seg lag the index by exactly 1 cycle.
  - Exactly one an bit is active while enable=1. No an bit is ever active together with another.
  - With enable=0, all an, seg and dp_out bits go inactive on the next edge.
- Decode, logical active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. The result is inverted when SEG_ACTIVE_LOW=1. dp_out = shadow dp[index], with the same polarity.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked when shadow nibbles k..DIGITS-1 are all zero and k>0.
  - A blanked digit has seg and dp_out inactive, but its an is still driven, so scan timing is unchanged.
  - Digit 0 is never blanked. With all-zero value, only "0" shows on digit 0.
- Simultaneous events:
  - load together with an index advance: the newly selected digit shows the new shadow contents one cycle after that edge.
  - rst has priority over load and enable.
- Reset mid-scan: the scan restarts at digit 0 with a full REFRESH_DIV dwell, once enable is high after reset.
- Timing from the first edge with enable=1 after reset: digit 0 lights on that edge+1, and digit 1 lights REFRESH_DIV cycles later.

Decomposition:
- Package seg_pkg holds:
  - the 16-entry segment code table (logical active-high);
  - the SEG_OFF constant;
  - the segment bit-index constants (SEG_A..SEG_G).
- Sub-module seg_hex_decode: combinational 4-bit nibble -> 7-bit logical pattern, instantiated once on the muxed nibble.
- The top level holds the counter, index, shadow registers, blanking logic, polarity inversion and output registers.

Test Plan (DIGITS=4, REFRESH_DIV=4, both active-low):
- Reset, then enable=1 with no load -> an=1110, seg=7'b1000000 (the "0" pattern, 3F inverted) on digit 0; an steps 1101, 1011, 0111, 1110 every 4 cycles; seg shows 0 on all digits.
- load value=16'h9A3F, dp=4'b0100 -> digits 0..3 show seg 0001110 (F), 0110000 (3), 0001000 (A), 0010000 (9); dp_out=0 only while an=1011.
- blank_lz=1, load value=16'h0050 -> digits 3 and 2 blanked (seg=7F, an still cycles); digit 1 shows 5 (0010010); digit 0 shows 0 (1000000).
- enable dropped mid-dwell on digit 2 -> next edge an=1111 and seg=7F. Re-enable -> digit 2 resumes with its remaining dwell count preserved.
- load asserted on the edge the index advances 0->1 -> digit 1 shows the new nibble on the first cycle it is lit.
- rst pulsed while digit 3 is lit and a load is pending -> shadow=0, an=1111 the next cycle, and the scan restarts at digit 0.
